// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending machine.
// Prices are stored in nickel units, one byte per item, item 0 in the low byte.
package vend_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        VEND   = 2'd1,
        REFUND = 2'd2
    } state_t;

    localparam int NICKEL_V  = 1;
    localparam int DIME_V    = 2;
    localparam int QUARTER_V = 5;

    localparam int MAX_PRICE_ITEMS = 32;
    localparam int PRICE_VEC_W     = 8 * MAX_PRICE_ITEMS;

    localparam logic [31:0] DEFAULT_PRICES = {8'd7, 8'd5, 8'd4, 8'd3};

    function automatic logic [7:0] price_at(input logic [PRICE_VEC_W-1:0] prices,
                                            input int unsigned idx);
        return prices[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-item stock counters; restock of an item overrides a same-cycle decrement.
// The empty flag reflects the currently selected item.
module vend_inventory #(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = $clog2(NUM_ITEMS),
    parameter int INV_W      = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             dec,
    input  logic             restock,
    output logic             empty
);

    localparam logic [INV_W-1:0] STOCK_INIT = INV_W'(INIT_STOCK);
    localparam logic [INV_W-1:0] STOCK_ZERO = {INV_W{1'b0}};
    localparam logic [INV_W-1:0] STOCK_ONE  = {{(INV_W-1){1'b0}}, 1'b1};

    logic [INV_W-1:0] stock_r [NUM_ITEMS];

    // Stock counters: reload on restock, saturating decrement on a vend.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_r[i] <= STOCK_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock && (sel == SEL_W'(i))) begin
                    stock_r[i] <= STOCK_INIT;
                end else if (dec && (sel == SEL_W'(i)) && (stock_r[i] != STOCK_ZERO)) begin
                    stock_r[i] <= stock_r[i] - STOCK_ONE;
                end else begin
                    stock_r[i] <= stock_r[i];
                end
            end
        end
    end

    assign empty = (stock_r[sel] == STOCK_ZERO);

endmodule

// File: rtl/vend_machine_multi.sv
// Multi-item vending controller: coin credit, vend, cancel and serial nickel change.
// Outputs are registered so that each pulse coincides with the state it belongs to.
module vend_machine_multi
    import vend_pkg::*;
#(
    parameter int                     NUM_ITEMS  = 4,
    parameter int                     SEL_W      = $clog2(NUM_ITEMS),
    parameter int                     CREDIT_W   = 6,
    parameter int                     MAX_CREDIT = 20,
    parameter logic [8*NUM_ITEMS-1:0] PRICES     = DEFAULT_PRICES,
    parameter int                     INV_W      = 4,
    parameter int                     INIT_STOCK = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SEL_W-1:0]    item_sel,
    input  logic                vend_req,
    input  logic                cancel,
    input  logic                restock,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                quarter_in,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispensed_item,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                low_credit,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] CREDIT_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_W:0]   CREDIT_CAP  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [PRICE_VEC_W-1:0] PRICE_VEC = PRICE_VEC_W'(PRICES);

    state_t              state_r, state_s;
    logic [CREDIT_W-1:0] credit_r, credit_s, price_s, coin_add_s;
    logic [SEL_W-1:0]    item_s;
    logic [CREDIT_W:0]   sum_s;
    logic [2:0]          coin_v_s;
    logic [1:0]          n_coins_s;
    logic                coin_ok_s, any_coin_s, empty_s, dec_s;
    logic                dispense_s, nickel_s, reject_s, sold_s, low_s;

    vend_inventory #(
        .NUM_ITEMS (NUM_ITEMS),
        .SEL_W     (SEL_W),
        .INV_W     (INV_W),
        .INIT_STOCK(INIT_STOCK)
    ) u_inv (
        .clock  (clock),
        .reset  (reset),
        .sel    (item_sel),
        .dec    (dec_s),
        .restock(restock),
        .empty  (empty_s)
    );

    // Coin decode: a coin is credited only if it is the sole strobe and fits under the cap.
    always_comb begin
        n_coins_s = {1'b0, nickel_in} + {1'b0, dime_in} + {1'b0, quarter_in};
        if (nickel_in) begin
            coin_v_s = 3'(NICKEL_V);
        end else if (dime_in) begin
            coin_v_s = 3'(DIME_V);
        end else if (quarter_in) begin
            coin_v_s = 3'(QUARTER_V);
        end else begin
            coin_v_s = 3'd0;
        end
        any_coin_s = (n_coins_s != 2'd0);
        sum_s      = {1'b0, credit_r} + (CREDIT_W+1)'(coin_v_s);
        coin_ok_s  = (n_coins_s == 2'd1) && (sum_s <= CREDIT_CAP);
        coin_add_s = coin_ok_s ? CREDIT_W'(coin_v_s) : CREDIT_ZERO;
        price_s    = CREDIT_W'(price_at(PRICE_VEC, 32'(item_sel)));
    end

    // Next-state, credit and output-pulse logic.
    always_comb begin
        state_s  = state_r;
        credit_s = credit_r;
        item_s   = dispensed_item;
        dec_s    = 1'b0;
        reject_s = 1'b0;
        sold_s   = 1'b0;
        low_s    = 1'b0;
        case (state_r)
            ACCEPT: begin
                if (cancel) begin
                    reject_s = any_coin_s;
                    if (credit_r != CREDIT_ZERO) begin
                        state_s = REFUND;
                    end else begin
                        state_s = ACCEPT;
                    end
                end else begin
                    reject_s = any_coin_s && !coin_ok_s;
                    // The purchase is judged on the credit held before this edge's coin.
                    if (vend_req && !empty_s && (credit_r >= price_s)) begin
                        credit_s = credit_r - price_s + coin_add_s;
                        dec_s    = 1'b1;
                        item_s   = item_sel;
                        state_s  = VEND;
                    end else begin
                        credit_s = credit_r + coin_add_s;
                        sold_s   = vend_req && empty_s;
                        low_s    = vend_req && !empty_s && (credit_r < price_s);
                    end
                end
            end
            VEND: begin
                reject_s = any_coin_s;
                if (credit_r != CREDIT_ZERO) begin
                    state_s = REFUND;
                end else begin
                    state_s = ACCEPT;
                end
            end
            REFUND: begin
                reject_s = any_coin_s;
                if (credit_r <= CREDIT_ONE) begin
                    credit_s = CREDIT_ZERO;
                    state_s  = ACCEPT;
                end else begin
                    credit_s = credit_r - CREDIT_ONE;
                    state_s  = REFUND;
                end
            end
            default: begin
                state_s  = ACCEPT;
                credit_s = CREDIT_ZERO;
            end
        endcase
        dispense_s = (state_s == VEND);
        nickel_s   = (state_s == REFUND);
    end

    // State, credit and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ACCEPT;
            credit_r       <= CREDIT_ZERO;
            dispensed_item <= {SEL_W{1'b0}};
            dispense       <= 1'b0;
            nickel_out     <= 1'b0;
            coin_reject    <= 1'b0;
            sold_out       <= 1'b0;
            low_credit     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_r        <= state_s;
            credit_r       <= credit_s;
            dispensed_item <= item_s;
            dispense       <= dispense_s;
            nickel_out     <= nickel_s;
            coin_reject    <= reject_s;
            sold_out       <= sold_s;
            low_credit     <= low_s;
            busy           <= (state_s != ACCEPT);
        end
    end

    assign credit = credit_r;

endmodule

// File: tb/tb_vend_machine_multi.sv
// Scoreboard bench for vend_machine_multi: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT raises each output.
module tb_vend_machine_multi;

    localparam int SEL_W    = 2;
    localparam int CREDIT_W = 6;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [SEL_W-1:0]    item_sel = '0;
    logic                vend_req = 1'b0, cancel = 1'b0, restock = 1'b0;
    logic                nickel_in = 1'b0, dime_in = 1'b0, quarter_in = 1'b0;
    logic                dispense, nickel_out, coin_reject, sold_out, low_credit, busy;
    logic [SEL_W-1:0]    dispensed_item;
    logic [CREDIT_W-1:0] credit;

    int tests = 0;
    int fails = 0;

    // Expected pulses: dispense holds the item index, the others the credit seen with the pulse.
    int disp_q[$];
    int nick_q[$];
    int rej_q[$];
    int sold_q[$];
    int low_q[$];

    vend_machine_multi dut (
        .clock         (clock),
        .reset         (reset),
        .item_sel      (item_sel),
        .vend_req      (vend_req),
        .cancel        (cancel),
        .restock       (restock),
        .nickel_in     (nickel_in),
        .dime_in       (dime_in),
        .quarter_in    (quarter_in),
        .dispense      (dispense),
        .dispensed_item(dispensed_item),
        .nickel_out    (nickel_out),
        .coin_reject   (coin_reject),
        .sold_out      (sold_out),
        .low_credit    (low_credit),
        .credit        (credit),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void pop_check(input string name, ref int q[$], input int act);
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected pulse (value %0d), expected none (t=%0t)", name, act, $time);
        end else begin
            check(name, act, q.pop_front());
        end
    endfunction

    always @(negedge clock) begin
        if (dispense)    pop_check("dispense_item", disp_q, int'(dispensed_item));
        if (nickel_out)  pop_check("nickel_out_credit", nick_q, int'(credit));
        if (coin_reject) pop_check("coin_reject_credit", rej_q, int'(credit));
        if (sold_out)    pop_check("sold_out_credit", sold_q, int'(credit));
        if (low_credit)  pop_check("low_credit_credit", low_q, int'(credit));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic coin(input logic n, input logic d, input logic q);
        nickel_in = n; dime_in = d; quarter_in = q;
        @(negedge clock);
        nickel_in = 1'b0; dime_in = 1'b0; quarter_in = 1'b0;
    endtask

    task automatic vend(input int sel);
        item_sel = SEL_W'(sel);
        vend_req = 1'b1;
        @(negedge clock);
        vend_req = 1'b0;
    endtask

    task automatic do_cancel(input int k);
        for (int i = k; i > 0; i--) nick_q.push_back(i);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
    endtask

    task automatic paid_vend0();
        repeat (3) coin(1'b1, 1'b0, 1'b0);
        disp_q.push_back(0);
        vend(0);
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dispense"}, int'(dispense), 0);
        check({tag, "_nickel_out"}, int'(nickel_out), 0);
        check({tag, "_coin_reject"}, int'(coin_reject), 0);
        check({tag, "_sold_out"}, int'(sold_out), 0);
        check({tag, "_low_credit"}, int'(low_credit), 0);
        check({tag, "_credit"}, int'(credit), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_item"}, int'(dispensed_item), 0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        tick(1);

        // Exact payment for item 0: no change.
        repeat (3) coin(1'b1, 1'b0, 1'b0);
        check("credit_3_nickels", int'(credit), 3);
        disp_q.push_back(0);
        vend(0);
        check("busy_in_vend", int'(busy), 1);
        tick(2);
        check("credit_after_item0", int'(credit), 0);
        check("busy_after_item0", int'(busy), 0);

        // Quarter for item 1 (20c): one nickel of change.
        coin(1'b0, 1'b0, 1'b1);
        disp_q.push_back(1);
        nick_q.push_back(1);
        vend(1);
        tick(4);
        check("credit_after_item1", int'(credit), 0);

        // Two quarters for item 3 (35c): three nickels of change.
        coin(1'b0, 1'b0, 1'b1);
        coin(1'b0, 1'b0, 1'b1);
        check("credit_2_quarters", int'(credit), 10);
        disp_q.push_back(3);
        nick_q.push_back(3); nick_q.push_back(2); nick_q.push_back(1);
        vend(3);
        tick(6);
        check("credit_after_item3", int'(credit), 0);
        check("busy_after_item3", int'(busy), 0);

        // Cap at 100c and multi-strobe rejection.
        repeat (4) coin(1'b0, 1'b0, 1'b1);
        check("credit_cap", int'(credit), 20);
        rej_q.push_back(20);
        coin(1'b0, 1'b1, 1'b0);
        check("credit_after_over_dime", int'(credit), 20);
        rej_q.push_back(20);
        coin(1'b1, 1'b1, 1'b0);
        check("credit_after_double", int'(credit), 20);
        do_cancel(20);
        tick(22);
        check("credit_after_cap_refund", int'(credit), 0);

        // Low credit on item 2, then cancel refunds two nickels.
        repeat (2) coin(1'b1, 1'b0, 1'b0);
        low_q.push_back(2);
        vend(2);
        check("credit_after_low", int'(credit), 2);
        do_cancel(2);
        check("busy_in_refund", int'(busy), 1);
        tick(3);
        check("credit_after_cancel", int'(credit), 0);
        check("busy_after_cancel", int'(busy), 0);

        // Sold-out after eight item-0 vends from a full restock.
        item_sel = 2'd0; restock = 1'b1; tick(1); restock = 1'b0;
        repeat (8) paid_vend0();
        repeat (3) coin(1'b1, 1'b0, 1'b0);
        sold_q.push_back(3);
        vend(0);
        check("credit_kept_sold_out", int'(credit), 3);
        item_sel = 2'd0; restock = 1'b1; tick(1); restock = 1'b0;
        disp_q.push_back(0);
        vend(0);
        tick(2);
        check("credit_after_restock_vend", int'(credit), 0);

        // Coin and vend during a refund: coin rejected, refund unaffected.
        repeat (3) coin(1'b1, 1'b0, 1'b0);
        do_cancel(3);
        rej_q.push_back(2);
        item_sel = 2'd1; vend_req = 1'b1; dime_in = 1'b1;
        tick(1);
        vend_req = 1'b0; dime_in = 1'b0;
        tick(3);
        check("credit_after_busy_refund", int'(credit), 0);
        check("busy_after_busy_refund", int'(busy), 0);

        // Reset in the middle of a refund aborts it.
        repeat (3) coin(1'b1, 1'b0, 1'b0);
        do_cancel(3);
        tick(1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        nick_q.delete();
        tick(1);
        reset = 1'b1;
        tick(1);

        // Stock restored: eight vends succeed, the ninth is sold out.
        repeat (8) paid_vend0();
        repeat (3) coin(1'b1, 1'b0, 1'b0);
        sold_q.push_back(3);
        vend(0);
        tick(1);
        do_cancel(3);
        tick(5);
        check("credit_final", int'(credit), 0);

        check("pending_dispense", disp_q.size(), 0);
        check("pending_nickel", nick_q.size(), 0);
        check("pending_reject", rej_q.size(), 0);
        check("pending_sold_out", sold_q.size(), 0);
        check("pending_low_credit", low_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_machine_multi.md
Name: vend_machine_multi

Overview:
- Parametrised successor to the fixed 3-item nickel/dime vending machine.
- Supports N items with per-item prices, a nickel/dime/quarter coin front end and a credit accumulator.
- Adds per-item inventory with sold-out detection, cancel/refund, an over-credit coin reject, and multi-nickel serial change return.
- Sits between the coin acceptor and the dispenser/change-hopper drivers; one vend transaction at a time.

Parameters:
- NUM_ITEMS, 4, number of selectable items (>=2).
- SEL_W, $clog2(NUM_ITEMS), item select width (derived).
- CREDIT_W, 6, credit register width, in nickel units.
- MAX_CREDIT, 20, credit cap in nickels (100c); must be < 2**CREDIT_W.
- PRICES, {8'd7,8'd5,8'd4,8'd3}, packed per-item prices in nickels; item0=15c, item1=20c, item2=25c, item3=35c; each price must be 1..MAX_CREDIT.
- INV_W, 4, stock counter width per item.
- INIT_STOCK, 8, stock loaded at reset and on restock; must be < 2**INV_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- item_sel  in  SEL_W  item index, sampled with vend_req/restock.
- vend_req  in  1  1-cycle purchase request.
- cancel  in  1  1-cycle refund-all request.
- restock  in  1  1-cycle pulse: stock[item_sel] <= INIT_STOCK.
- nickel_in, dime_in, quarter_in  in  1 each  1-cycle coin strobes (1, 2, 5 nickels).
- dispense  out  1  1-cycle pulse, item released.
- dispensed_item  out  SEL_W  index of the vended item; valid with dispense.
- nickel_out  out  1  one pulse per nickel of change/refund.
- coin_reject  out  1  1-cycle pulse, coin returned and not credited.
- sold_out  out  1  1-cycle pulse, vend_req on an empty item.
- low_credit  out  1  1-cycle pulse, vend_req with credit < price.
- credit  out  CREDIT_W  current credit in nickels.
- busy  out  1  high in VEND or REFUND.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state ACCEPT, credit 0, all stock = INIT_STOCK. Asserting reset mid-transaction discards credit and aborts any change in progress.
- FSM states: ACCEPT, VEND, REFUND.
- ACCEPT, coins:
  - Coin value coin_v is the nickel count of the single asserted strobe.
  - If more than one strobe is asserted, or credit + coin_v > MAX_CREDIT: coin_reject = 1 next cycle and credit is unchanged.
- ACCEPT, priority order per edge: cancel > vend_req > idle. Coin handling applies in parallel, except that a coin arriving with cancel is rejected.
  - cancel with credit > 0: go to REFUND. cancel with credit == 0: no effect.
  - vend_req: price p = PRICES[item_sel], compared against the registered credit (a coin in the same cycle does not count toward this purchase).
    - stock == 0: sold_out pulse; stay in ACCEPT.
    - Otherwise credit < p: low_credit pulse; stay in ACCEPT.
    - Otherwise: credit <= credit - p + accepted coin_v; stock[item_sel] decremented; dispensed_item latched; go to VEND.
- VEND, one cycle: dispense = 1. If credit > 0 go to REFUND, else go to ACCEPT.
- REFUND, each cycle: nickel_out = 1 and credit decremented. The transition to ACCEPT occurs on the edge where credit reaches 0. A refund of k nickels gives k consecutive nickel_out cycles.
- Timing example: vend at edge k; dispense high during cycle k+1; first nickel_out during cycle k+2.
- In VEND/REFUND: all coins are rejected (coin_reject pulse), vend_req and cancel are ignored, and no sold_out/low_credit pulses are produced.
- restock is honoured in any state. If restock and a vend target the same item in the same cycle, the final stock is INIT_STOCK.
- Stock never wraps below 0. Credit never exceeds MAX_CREDIT.

Decomposition:
- Package vend_pkg:
  - state enum (ACCEPT/VEND/REFUND);
  - coin value constants NICKEL_V=1, DIME_V=2, QUARTER_V=5;
  - default PRICES vector;
  - price-extract function.
- Sub-module vend_inventory: NUM_ITEMS x INV_W stock counters with decrement/restock ports and an empty flag for the selected item.
- FSM and credit logic stay in the top level.

Test Plan:
- item_sel=0, 3 nickels, vend_req -> credit 3; dispense one cycle after vend with dispensed_item=0; no nickel_out; credit 0.
- item_sel=1, quarter, vend_req -> dispense, then exactly 1 nickel_out; stock[1]=7. Repeat with item_sel=3 and 2 quarters -> 3 consecutive nickel_out pulses.
- Insert 4 quarters (credit 20), then a dime -> coin_reject, credit stays 20. Assert dime_in and nickel_in together -> coin_reject, credit unchanged.
- item_sel=2, 2 nickels, vend_req -> low_credit, no dispense. Then cancel -> 2 nickel_out pulses, credit 0, busy back low.
- Vend item0 eight times -> ninth vend_req gives sold_out, credit retained. restock with item_sel=0, then vend -> dispense.
- During a 3-nickel refund, pulse dime_in and vend_req -> coin_reject only, refund completes unchanged. Assert reset mid-refund -> all outputs 0, credit 0, stock INIT_STOCK.
